ccff_bitstream_loader: RTL

- Configuration-chain controller for the CLB/FLE fabric.
- Accepts configuration words over a valid/ready stream and serialises them, one bit per prog_clk, into the ccff_head of the tile configuration flip-flop chain.
- Counts exactly CHAIN_LEN bits, reports busy/done status, and supports abort.
- Sits between the programming interface (SPI/Wishbone bridge) and the top-level ccff chain.

---
 rtl/ccff_bitstream_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serialises config words into the ccff chain head, MSB first
// Optional running CRC-16-CCITT of shifted bits: define CCFF_LOADER_CRC_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [15:0]       crc
);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BW-1:0]    LAST_IDX = BW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t            state, state_nx;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bit_idx;
  logic              accept, load_start, shift_now, chain_end, word_end;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state <= IDLE;
    else         state <= state_nx;
  end

  // abort outranks everything, so it also masks ready to avoid a phantom handshake
  always_comb begin
    state_nx   = state;
    cfg_ready  = 1'b0;
    accept     = 1'b0;
    load_start = 1'b0;
    shift_now  = 1'b0;
    chain_end  = (bit_count == LAST_BIT);
    word_end   = (bit_idx == LAST_IDX) || chain_end;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx   = WAIT_WORD;
            load_start = 1'b1;
          end
        end
        WAIT_WORD: begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            accept   = 1'b1;
            state_nx = SHIFT;
          end
        end
        SHIFT: begin
          shift_now = 1'b1;
          if (word_end) state_nx = chain_end ? DONE : WAIT_WORD;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shreg     <= '0;
      bit_idx   <= '0;
      ccff_head <= 1'b0;
      ccff_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
    end else begin
      ccff_en <= shift_now;
      if (abort) begin
        busy <= 1'b0;
        done <= 1'b0;
      end else begin
        if (load_start) begin
          bit_count <= '0;
          done      <= 1'b0;
          busy      <= 1'b1;
        end
        if (accept) begin
          shreg   <= cfg_data;
          bit_idx <= '0;
        end
        if (shift_now) begin
          ccff_head <= shreg[WORD_W-1];
          shreg     <= shreg << 1;
          bit_idx   <= bit_idx + 1'b1;
          bit_count <= bit_count + 1'b1;
          if (chain_end) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] crc_q;
  logic        crc_fb;

  assign crc_fb = crc_q[15] ^ shreg[WORD_W-1];

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset)        crc_q <= 16'hFFFF;
    else if (load_start) crc_q <= 16'hFFFF;
    else if (shift_now)  crc_q <= {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

endmodule
